// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer for the 4-bit accumulator datapath.
// Fetches a 5-bit instruction from the program store at pc. It then runs it
// as FETCH -> EXEC -> WB, with one bus driver held across EXEC and WB and the
// write pulse in WB only. Supports free-run, single-step and halt.
//
// Ports:
//   clk       system clock
//   clear     synchronous active-low reset
//   run       1 = free-running, 0 = step mode
//   step      step request, rising edge starts one instruction (run=0 only)
//   instr_in  program store word at address pc
//   pc        program counter / program store address
//   ir        latched instruction ([4:2] opcode, [1:0] operand)
//   oe_memo   data memory drives bus
//   oe_alu    ALU drives bus
//   oe_port   port drives bus
//   r_w       memory write cycle
//   clk1      register 1 load pulse
//   clk2      register 2 load pulse
//   clk_reg   port output register load pulse
//   halted    HALT executed
//   busy      instruction in progress
module seq_control_unit #(
  parameter int unsigned PC_W = 4,
  parameter int unsigned IR_W = 5
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            run,
  input  logic            step,
  input  logic [IR_W-1:0] instr_in,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic            oe_memo,
  output logic            oe_alu,
  output logic            oe_port,
  output logic            r_w,
  output logic            clk1,
  output logic            clk2,
  output logic            clk_reg,
  output logic            halted,
  output logic            busy
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [IR_W-1:0] ir_q;
  logic            step_q;
  logic [2:0]      oe_q;      // {memo, alu, port}
  logic [3:0]      wr_q;      // {clk1, clk2, clk_reg, r_w}
  logic            halted_q;

  logic [2:0]      fetch_oe;
  logic [3:0]      exec_wr;
  logic            exec_halt;
  logic            start;

  // Bus driver for an instruction: {memo, alu, port}.
  function automatic logic [2:0] bus_sel(input logic [IR_W-1:0] w);
    logic [2:0] op;
    logic [1:0] a;
    logic [2:0] sel;
    op  = w[IR_W-1 -: 3];
    a   = w[1:0];
    sel = 3'b000;
    case (op)
      3'b000, 3'b001: sel = 3'b100;
      3'b100, 3'b101: sel = 3'b010;
      3'b111:         if (a == 2'b00 || a == 2'b01) sel = 3'b001;
      default:        sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Write strobe for an instruction: {clk1, clk2, clk_reg, r_w}.
  function automatic logic [3:0] wr_sel(input logic [IR_W-1:0] w);
    logic [2:0] op;
    logic [1:0] a;
    logic [3:0] sel;
    op  = w[IR_W-1 -: 3];
    a   = w[1:0];
    sel = 4'b0000;
    case (op)
      3'b000, 3'b100: sel = 4'b1000;
      3'b001, 3'b101: sel = 4'b0100;
      3'b010, 3'b011: sel = 4'b0001;
      3'b110:         sel = 4'b0010;
      default: begin
        if (a == 2'b00)      sel = 4'b1000;
        else if (a == 2'b01) sel = 4'b0100;
        else                 sel = 4'b0000;
      end
    endcase
    return sel;
  endfunction

  always_comb begin
    fetch_oe  = bus_sel(instr_in);
    exec_wr   = wr_sel(ir_q);
    exec_halt = (ir_q[IR_W-1 -: 3] == 3'b111) && (ir_q[1:0] == 2'b11);
    // Step only counts in step mode; step_q is updated every cycle so an edge
    // seen while busy is consumed and never replayed in IDLE.
    start     = run || (step && !step_q);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ir_q     <= '0;
      step_q   <= 1'b0;
      oe_q     <= '0;
      wr_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q <= step;
      case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          ir_q    <= instr_in;
          // Bus enable is decoded from the fetched word so it is already
          // registered during EXEC.
          oe_q    <= fetch_oe;
          state_q <= StExec;
        end
        StExec: begin
          if (exec_halt) begin
            oe_q     <= '0;
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            wr_q    <= exec_wr;
            state_q <= StWb;
          end
        end
        StWb: begin
          oe_q    <= '0;
          wr_q    <= '0;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= run ? StFetch : StIdle;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign oe_memo = oe_q[2];
  assign oe_alu  = oe_q[1];
  assign oe_port = oe_q[0];
  assign clk1    = wr_q[3];
  assign clk2    = wr_q[2];
  assign clk_reg = wr_q[1];
  assign r_w     = wr_q[0];
  assign halted  = halted_q;
  assign busy    = (state_q == StFetch) || (state_q == StExec) || (state_q == StWb);

endmodule
